// File: rtl/counter_access_ctrl.sv
// ============================================================================
// counter_access_ctrl
//
// Round-robin controller that shares one bus-attached counter between
// NUM_REQ requesters (e.g. a fetch unit and a branch unit sharing the PC).
// Each granted operation (READ, WRITE, INC, READ_INC) becomes exactly one
// counter access cycle (EXEC), followed by one response cycle (RESP) in
// which the owner receives a done pulse and any read data.
//
// Sequence per operation: IDLE -> EXEC -> RESP -> IDLE. Back-to-back
// operations therefore complete every 3 cycles.
//
// Parameters
//   NUM_REQ     number of requesters, legal 2..4
//   DATA_WIDTH  counter / bus width (defaults to `DATA_WIDTH, 8 if unset)
//
// Ports
//   clk         clock, all state on posedge
//   reset       asynchronous, active-low reset
//   req         request per requester, held until its done
//   op          op per requester, [2i+1:2i]: 00 READ, 01 WRITE, 10 INC, 11 READ_INC
//   wdata       write data per requester, slice i
//   gnt         one-hot owner, high during EXEC and RESP
//   done        one-cycle completion pulse to the owner (RESP)
//   rdata       read result, valid while done is high, held afterwards
//   ctr_cs      counter chip select (EXEC only)
//   ctr_we      counter write enable (WRITE)
//   ctr_oe      counter output enable (READ, READ_INC)
//   ctr_cnt_en  counter count enable (INC, READ_INC)
//   bus_in      shared data bus as seen by the controller
//   bus_out     value driven onto the bus during WRITE
//   bus_oe      tri-state enable for bus_out (EXEC of WRITE only)
//   op_count    completed-operation counter, wraps 16'hFFFF -> 0
//
// Configuration
//   CTR_ACCESS_OPCNT_EN  defined: op_count counts completed operations.
//                        undefined: op_count tied to zero, no register.
// ============================================================================

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module counter_access_ctrl #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = `DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [2*NUM_REQ-1:0]          op,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          ctr_cs,
    output logic                          ctr_we,
    output logic                          ctr_oe,
    output logic                          ctr_cnt_en,
    input  logic [DATA_WIDTH-1:0]         bus_in,
    output logic [DATA_WIDTH-1:0]         bus_out,
    output logic                          bus_oe,
    output logic [15:0]                   op_count
);

    localparam int          IDX_W = (NUM_REQ > 2) ? 2 : 1;
    localparam int unsigned N_U   = NUM_REQ;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        OP_READ     = 2'b00,
        OP_WRITE    = 2'b01,
        OP_INC      = 2'b10,
        OP_READ_INC = 2'b11
    } op_t;

    state_t                  state;
    state_t                  state_next;

    logic [IDX_W-1:0]        owner;
    logic [IDX_W-1:0]        rr_ptr;
    op_t                     op_q;
    logic [DATA_WIDTH-1:0]   wdata_q;

    logic [1:0]              op_arr    [NUM_REQ];
    logic [DATA_WIDTH-1:0]   wdata_arr [NUM_REQ];

    logic                    pick_valid;
    logic [IDX_W-1:0]        pick_idx;
    int unsigned             cand;

    logic                    is_read_op;

    // ------------------------------------------------------------------
    // Per-requester views of the packed op / wdata buses
    // ------------------------------------------------------------------
    always_comb begin
        for (int unsigned i = 0; i < N_U; i++) begin
            op_arr[i]    = op[2*i +: 2];
            wdata_arr[i] = wdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // ------------------------------------------------------------------
    // Round-robin pick: first requester at or after rr_ptr, cyclically.
    // ------------------------------------------------------------------
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int unsigned k = 0; k < N_U; k++) begin
            cand = 32'(rr_ptr) + k;
            if (cand >= N_U) begin
                cand = cand - N_U;
            end
            if (!pick_valid && req[cand[IDX_W-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign is_read_op = (op_q == OP_READ) || (op_q == OP_READ_INC);

    // ------------------------------------------------------------------
    // State register and latched transaction
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            owner   <= '0;
            rr_ptr  <= '0;
            op_q    <= OP_READ;
            wdata_q <= '0;
            rdata   <= '0;
        end else begin
            state <= state_next;

            // op and wdata are captured only at grant; later changes are ignored
            if (state == ST_IDLE && pick_valid) begin
                owner   <= pick_idx;
                op_q    <= op_t'(op_arr[pick_idx]);
                wdata_q <= wdata_arr[pick_idx];
            end

            // Counter drives the bus during EXEC of reads; for READ_INC this
            // is the pre-increment value since the count takes effect at
            // this same edge inside the counter.
            if (state == ST_EXEC && is_read_op) begin
                rdata <= bus_in;
            end

            if (state == ST_RESP) begin
                rr_ptr <= (owner == LAST_IDX) ? '0 : owner + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Completed-operation counter
    // ------------------------------------------------------------------
`ifdef CTR_ACCESS_OPCNT_EN
    logic [15:0] op_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_count_q <= '0;
        end else if (state == ST_RESP) begin
            op_count_q <= op_count_q + 16'd1;
        end
    end

    assign op_count = op_count_q;
`else
    assign op_count = '0;
`endif

    // ------------------------------------------------------------------
    // Next state and outputs (Moore, decoded from state and latched op)
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        gnt        = '0;
        done       = '0;
        ctr_cs     = 1'b0;
        ctr_we     = 1'b0;
        ctr_oe     = 1'b0;
        ctr_cnt_en = 1'b0;
        bus_out    = '0;
        bus_oe     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_next = ST_EXEC;
                end
            end

            ST_EXEC: begin
                gnt[owner] = 1'b1;
                ctr_cs     = 1'b1;
                case (op_q)
                    OP_READ: begin
                        ctr_oe = 1'b1;
                    end
                    OP_WRITE: begin
                        // Counter output stays disabled, so the controller
                        // is the only bus driver in this cycle.
                        ctr_we  = 1'b1;
                        bus_oe  = 1'b1;
                        bus_out = wdata_q;
                    end
                    OP_INC: begin
                        ctr_cnt_en = 1'b1;
                    end
                    OP_READ_INC: begin
                        ctr_oe     = 1'b1;
                        ctr_cnt_en = 1'b1;
                    end
                    default: begin
                        ctr_oe = 1'b0;
                    end
                endcase
                state_next = ST_RESP;
            end

            ST_RESP: begin
                gnt[owner]  = 1'b1;
                done[owner] = 1'b1;
                state_next  = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_counter_access_ctrl.sv
// ============================================================================
// tb_counter_access_ctrl
//
// Self-checking bench for counter_access_ctrl (NUM_REQ=2, DATA_WIDTH=8).
// A simple bus-attached counter device answers the controller's pins; the
// expected results come from a transaction-level model: one counter value
// updated per completed op, and a round-robin pointer advanced past each
// completed owner.
// ============================================================================

module tb_counter_access_ctrl;

    localparam int N  = 2;
    localparam int DW = 8;

    localparam logic [1:0] OP_READ     = 2'b00;
    localparam logic [1:0] OP_WRITE    = 2'b01;
    localparam logic [1:0] OP_INC      = 2'b10;
    localparam logic [1:0] OP_READ_INC = 2'b11;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [2*N-1:0]  op;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic [DW-1:0]   rdata;
    logic            ctr_cs;
    logic            ctr_we;
    logic            ctr_oe;
    logic            ctr_cnt_en;
    logic [DW-1:0]   bus_in;
    logic [DW-1:0]   bus_out;
    logic            bus_oe;
    logic [15:0]     op_count;

    int compared   = 0;
    int mismatched = 0;

    // Transaction-level reference state
    logic [DW-1:0] ctr_model = '0;
    int            rr_model  = 0;
    int            ops_since_reset = 0;

    // External counter device (not reset by the controller)
    logic [DW-1:0] dev_ctr = '0;

    counter_access_ctrl #(
        .NUM_REQ   (N),
        .DATA_WIDTH(DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .op        (op),
        .wdata     (wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .ctr_cs    (ctr_cs),
        .ctr_we    (ctr_we),
        .ctr_oe    (ctr_oe),
        .ctr_cnt_en(ctr_cnt_en),
        .bus_in    (bus_in),
        .bus_out   (bus_out),
        .bus_oe    (bus_oe),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    // Device writes whatever is on the bus; 8'hEE marks an undriven bus.
    always @(posedge clk) begin
        if (ctr_cs) begin
            if (ctr_we)
                dev_ctr <= bus_oe ? bus_out : 8'hEE;
            else if (ctr_cnt_en)
                dev_ctr <= dev_ctr + 8'd1;
        end
    end

    assign bus_in = (ctr_cs && ctr_oe) ? dev_ctr : 8'h5A;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input int p, input logic [N-1:0] m);
        for (int k = 0; k < N; k++) begin
            if (m[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] model_apply(input logic [1:0] o, input logic [DW-1:0] v,
                                                  input logic [DW-1:0] wd);
        case (o)
            OP_WRITE:    return wd;
            OP_INC:      return v + 8'd1;
            OP_READ_INC: return v + 8'd1;
            default:     return v;
        endcase
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        req   = '0;
        tick();
        reset = 1'b1;
        rr_model = 0;
        ops_since_reset = 0;
        tick();
    endtask

    // Drive one op from requester r and wait (bounded) for its done.
    task automatic do_op(input int r, input logic [1:0] o, input logic [DW-1:0] wd,
                         output bit got, output logic [DW-1:0] rd, output int cs_cyc,
                         output logic [3:0] strobes, output logic [DW-1:0] bo, output int lat);
        got = 0; rd = '0; cs_cyc = 0; strobes = '0; bo = '0; lat = 0;
        op[2*r +: 2]     = o;
        wdata[DW*r +: DW] = wd;
        req[r] = 1'b1;
        for (int c = 1; c <= 20 && !got; c++) begin
            tick();
            if (ctr_cs) begin
                cs_cyc++;
                strobes = {ctr_we, ctr_oe, ctr_cnt_en, bus_oe};
                bo = bus_out;
            end
            if (done[r]) begin
                got = 1;
                rd  = rdata;
                lat = c;
            end
        end
        req[r] = 1'b0;
        if (got) begin
            ctr_model = model_apply(o, ctr_model, wd);
            rr_model  = (r + 1) % N;
            ops_since_reset++;
        end
        tick();
    endtask

    task automatic test_reset();
        bit seen_done;
        reset = 1'b0; req = '0; op = '0; wdata = '0;
        repeat (2) tick();
        compared++;
        if ({gnt, done, ctr_cs, ctr_we, ctr_oe, ctr_cnt_en, bus_oe} !== '0) begin
            mismatched++;
            $display("FAIL reset_ctrl: got %b want 0", {gnt, done, ctr_cs, ctr_we, ctr_oe, ctr_cnt_en, bus_oe});
        end
        compared++;
        if ({rdata, bus_out, op_count} !== '0) begin
            mismatched++;
            $display("FAIL reset_data: rdata=%h bus_out=%h op_count=%h want 0", rdata, bus_out, op_count);
        end
        reset = 1'b1;
        tick();

        // Abort a WRITE in its EXEC cycle
        op[1:0] = OP_WRITE; wdata[7:0] = 8'h77; req[0] = 1'b1;
        tick();
        compared++;
        if (ctr_we !== 1'b1 || bus_oe !== 1'b1) begin
            mismatched++;
            $display("FAIL abort_exec_seen: we=%b bus_oe=%b want 1/1", ctr_we, bus_oe);
        end
        reset = 1'b0;
        #1;
        compared++;
        if ({gnt, done, ctr_cs, ctr_we, ctr_oe, ctr_cnt_en, bus_oe} !== '0) begin
            mismatched++;
            $display("FAIL abort_async: got %b want 0", {gnt, done, ctr_cs, ctr_we, ctr_oe, ctr_cnt_en, bus_oe});
        end
        req = '0;
        repeat (2) tick();
        reset = 1'b1;
        rr_model = 0;
        ops_since_reset = 0;
        seen_done = 0;
        repeat (6) begin
            tick();
            if (done !== '0) seen_done = 1;
        end
        compared++;
        if (seen_done) begin
            mismatched++;
            $display("FAIL abort_no_done: got done after reset release, want none");
        end
    endtask

    task automatic test_write_read();
        bit got; logic [DW-1:0] rd, bo; int cs_cyc, lat; logic [3:0] st;
        do_op(0, OP_WRITE, 8'h3C, got, rd, cs_cyc, st, bo, lat);
        compared++;
        if (!got || lat != 2) begin
            mismatched++;
            $display("FAIL write_latency: got=%0d lat=%0d want done at 2", got, lat);
        end
        compared++;
        if (st !== 4'b1001 || bo !== 8'h3C || cs_cyc != 1) begin
            mismatched++;
            $display("FAIL write_exec: we/oe/cnt/boe=%b bus_out=%h cs=%0d want 1001/3c/1", st, bo, cs_cyc);
        end
        do_op(0, OP_READ, 8'h00, got, rd, cs_cyc, st, bo, lat);
        compared++;
        if (!got || rd !== 8'h3C) begin
            mismatched++;
            $display("FAIL read_back: got=%0d rdata=%h want 3c", got, rd);
        end
        compared++;
        if (st !== 4'b0100 || cs_cyc != 1) begin
            mismatched++;
            $display("FAIL read_exec: we/oe/cnt/boe=%b cs=%0d want 0100/1", st, cs_cyc);
        end
        compared++;
        if (rdata !== 8'h3C) begin
            mismatched++;
            $display("FAIL rdata_hold: rdata=%h want 3c", rdata);
        end
    endtask

    task automatic test_read_inc_wrap();
        bit got; logic [DW-1:0] rd, bo, exp; int cs_cyc, lat; logic [3:0] st;
        do_op(0, OP_WRITE, 8'hFF, got, rd, cs_cyc, st, bo, lat);
        exp = ctr_model;
        do_op(0, OP_READ_INC, 8'h00, got, rd, cs_cyc, st, bo, lat);
        compared++;
        if (!got || rd !== exp || rd !== 8'hFF) begin
            mismatched++;
            $display("FAIL read_inc_pre: rdata=%h want ff", rd);
        end
        compared++;
        if (st !== 4'b0110 || cs_cyc != 1) begin
            mismatched++;
            $display("FAIL read_inc_exec: we/oe/cnt/boe=%b cs=%0d want 0110/1", st, cs_cyc);
        end
        do_op(0, OP_READ, 8'h00, got, rd, cs_cyc, st, bo, lat);
        compared++;
        if (!got || rd !== 8'h00) begin
            mismatched++;
            $display("FAIL read_after_wrap: rdata=%h want 00", rd);
        end
        do_op(1, OP_INC, 8'h00, got, rd, cs_cyc, st, bo, lat);
        compared++;
        if (!got || st !== 4'b0010 || cs_cyc != 1) begin
            mismatched++;
            $display("FAIL inc_exec: got=%0d we/oe/cnt/boe=%b cs=%0d want 0010/1", got, st, cs_cyc);
        end
        exp = ctr_model;
        do_op(1, OP_READ, 8'h00, got, rd, cs_cyc, st, bo, lat);
        compared++;
        if (!got || rd !== exp) begin
            mismatched++;
            $display("FAIL read_after_inc: rdata=%h want %h", rd, exp);
        end
    endtask

    task automatic test_round_robin();
        int n, last_cyc, exp;
        logic [N-1:0] one;
        do_reset();
        op = {OP_INC, OP_INC};
        req = 2'b11;
        n = 0; last_cyc = 0;
        for (int c = 1; c <= 60 && n < 6; c++) begin
            tick();
            if (done !== '0) begin
                exp = rr_pick(rr_model, 2'b11);
                one = '0; one[exp] = 1'b1;
                compared++;
                if (done !== one || gnt !== one) begin
                    mismatched++;
                    $display("FAIL rr_order[%0d]: done=%b gnt=%b want %b", n, done, gnt, one);
                end
                if (n > 0) begin
                    compared++;
                    if (c - last_cyc != 3) begin
                        mismatched++;
                        $display("FAIL rr_spacing[%0d]: gap=%0d want 3", n, c - last_cyc);
                    end
                end
                last_cyc = c;
                rr_model = (exp + 1) % N;
                ctr_model = ctr_model + 8'd1;
                ops_since_reset++;
                n++;
                if (n == 6) req = '0;
            end
        end
        req = '0;
        compared++;
        if (n != 6) begin
            mismatched++;
            $display("FAIL rr_timeout: completed=%0d want 6", n);
        end
        repeat (2) tick();
    endtask

    task automatic test_random();
        logic [N-1:0]  pm;
        logic [1:0]    so [N];
        logic [DW-1:0] sw [N];
        logic [N-1:0]  one;
        int            cur, budget;
        logic [1:0]    o;
        for (int round = 0; round < 30; round++) begin
            pm = N'($urandom_range(1, (1 << N) - 1));
            for (int r = 0; r < N; r++) begin
                so[r] = 2'($urandom_range(0, 3));
                sw[r] = 8'($urandom);
                op[2*r +: 2]      = so[r];
                wdata[DW*r +: DW] = sw[r];
            end
            req = pm;
            cur = -1;
            budget = 0;
            while (pm != '0 && budget < 100) begin
                tick();
                budget++;
                compared++;
                if ((ctr_we && ctr_oe) || (bus_oe && !(ctr_cs && ctr_we))) begin
                    mismatched++;
                    $display("FAIL bus_rules: cs=%b we=%b oe=%b bus_oe=%b", ctr_cs, ctr_we, ctr_oe, bus_oe);
                end
                if (ctr_cs) begin
                    cur = rr_pick(rr_model, pm);
                    one = '0; one[cur] = 1'b1;
                    o = so[cur];
                    compared++;
                    if (gnt !== one
                        || ctr_we !== (o == OP_WRITE)
                        || ctr_oe !== (o == OP_READ || o == OP_READ_INC)
                        || ctr_cnt_en !== (o == OP_INC || o == OP_READ_INC)
                        || bus_oe !== (o == OP_WRITE)
                        || (o == OP_WRITE && bus_out !== sw[cur])) begin
                        mismatched++;
                        $display("FAIL rand_exec: gnt=%b we=%b oe=%b cnt=%b boe=%b bus_out=%h want owner %0d op %b wdata %h",
                                 gnt, ctr_we, ctr_oe, ctr_cnt_en, bus_oe, bus_out, cur, o, sw[cur]);
                    end
                    // Post-grant changes must not affect the running op
                    op[2*cur +: 2]      = 2'($urandom_range(0, 3));
                    wdata[DW*cur +: DW] = 8'($urandom);
                end
                if (done !== '0) begin
                    one = '0;
                    if (cur >= 0) one[cur] = 1'b1;
                    compared++;
                    if (cur < 0 || done !== one) begin
                        mismatched++;
                        $display("FAIL rand_done: done=%b want %b", done, one);
                    end
                    if (cur >= 0) begin
                        if (so[cur] == OP_READ || so[cur] == OP_READ_INC) begin
                            compared++;
                            if (rdata !== ctr_model) begin
                                mismatched++;
                                $display("FAIL rand_rdata: rdata=%h want %h", rdata, ctr_model);
                            end
                        end
                        ctr_model = model_apply(so[cur], ctr_model, sw[cur]);
                        rr_model  = (cur + 1) % N;
                        ops_since_reset++;
                        req[cur] = 1'b0;
                        pm[cur]  = 1'b0;
                        cur = -1;
                    end
                end
            end
            compared++;
            if (pm != '0) begin
                mismatched++;
                $display("FAIL rand_timeout: pending=%b want 0", pm);
            end
            req = '0;
            tick();
        end
    endtask

    task automatic test_op_count();
        bit got; logic [DW-1:0] rd, bo; int cs_cyc, lat; logic [3:0] st;
        int exp;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            do_op(int'($urandom_range(0, N - 1)), 2'($urandom_range(0, 3)), 8'($urandom),
                  got, rd, cs_cyc, st, bo, lat);
        end
`ifdef CTR_ACCESS_OPCNT_EN
        exp = ops_since_reset;
`else
        exp = 0;
`endif
        compared++;
        if (op_count !== 16'(exp)) begin
            mismatched++;
            $display("FAIL op_count: got %0d want %0d", op_count, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        req   = '0;
        op    = '0;
        wdata = '0;
        test_reset();
        test_write_read();
        test_read_inc_wrap();
        test_round_robin();
        test_random();
        test_op_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
